// File: rtl/gshare_predictor.sv
// gshare branch predictor: PC^GHR-indexed saturating counters, speculative global
// history, JAL/BRANCH target decode and ROB-driven training with history repair.
module gshare_predictor #(
    parameter int IDX_W = 10,
    parameter int CNT_W = 2,
    parameter int GHR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              query_valid,
    input  logic [31:0]       query_pc,
    input  logic [31:0]       query_instr,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [31:0]       pred_pc,
    output logic [GHR_W-1:0]  pred_ghr,
    input  logic              commit_valid,
    input  logic [31:0]       commit_pc,
    input  logic [GHR_W-1:0]  commit_ghr,
    input  logic              commit_taken,
    input  logic              commit_mispredict,
    output logic              init_done
);

    localparam int               DEPTH    = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [6:0]       OP_JAL    = 7'b1101111;
    localparam logic [6:0]       OP_BRANCH = 7'b1100011;

    if (GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_ghr_w
        $error("gshare_predictor: GHR_W must satisfy 1 <= GHR_W <= IDX_W");
    end
    if (CNT_W < 2) begin : g_bad_cnt_w
        $error("gshare_predictor: CNT_W must be at least 2");
    end

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   sweepPtr_q, sweepPtr_d;
    logic [GHR_W-1:0]   ghr_q, ghr_d;
    logic               predValid_q, predValid_d;
    logic               predTaken_q, predTaken_d;
    logic [31:0]        predPc_q, predPc_d;
    logic [GHR_W-1:0]   predGhr_q, predGhr_d;
    logic               initDone_q, initDone_d;

    logic [CNT_W-1:0]   table_q [DEPTH];

    logic               inRun;
    logic [6:0]         opcode;
    logic               isJal;
    logic               isBranch;
    logic [31:0]        jalImm;
    logic [31:0]        brImm;
    logic [IDX_W-1:0]   queryIdx;
    logic [CNT_W-1:0]   queryCnt;
    logic               branchTaken;
    logic               queryTaken;
    logic [31:0]        queryTarget;
    logic [GHR_W-1:0]   ghrShifted;
    logic [GHR_W-1:0]   ghrRepaired;
    logic [IDX_W-1:0]   commitIdx;
    logic [CNT_W-1:0]   commitCnt;
    logic [CNT_W-1:0]   commitCntNext;
    logic               unusedCommitPc;

    assign inRun    = (state_q == RUN);
    assign opcode   = query_instr[6:0];
    assign isJal    = (opcode == OP_JAL);
    assign isBranch = (opcode == OP_BRANCH);

    assign jalImm = {{11{query_instr[31]}}, query_instr[31], query_instr[19:12],
                     query_instr[20], query_instr[30:21], 1'b0};
    assign brImm  = {{19{query_instr[31]}}, query_instr[31], query_instr[7],
                     query_instr[30:25], query_instr[11:8], 1'b0};

    // Until the sweep finishes the counters are not trustworthy, so branches fall back to not-taken.
    assign queryIdx    = query_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign queryCnt    = table_q[queryIdx];
    assign branchTaken = isBranch && inRun && queryCnt[CNT_W-1];
    assign queryTaken  = isJal || branchTaken;

    always_comb begin
        queryTarget = query_pc + 32'd4;
        if (isJal) begin
            queryTarget = query_pc + jalImm;
        end else if (branchTaken) begin
            queryTarget = query_pc + brImm;
        end
    end

    if (GHR_W == 1) begin : g_ghr_one
        assign ghrShifted  = branchTaken;
        assign ghrRepaired = commit_taken;
    end else begin : g_ghr_multi
        assign ghrShifted  = {ghr_q[GHR_W-2:0], branchTaken};
        assign ghrRepaired = {commit_ghr[GHR_W-2:0], commit_taken};
    end

    assign commitIdx      = commit_pc[IDX_W+1:2] ^ IDX_W'(commit_ghr);
    assign commitCnt      = table_q[commitIdx];
    assign unusedCommitPc = ^{commit_pc[31:IDX_W+2], commit_pc[1:0]};

    always_comb begin
        commitCntNext = commitCnt;
        if (commit_taken) begin
            if (commitCnt != CNT_MAX) begin
                commitCntNext = commitCnt + CNT_W'(1);
            end
        end else if (commitCnt != '0) begin
            commitCntNext = commitCnt - CNT_W'(1);
        end
    end

    // Everything is frozen while rdy is low, including the pred_valid pulse.
    always_comb begin
        state_d     = state_q;
        sweepPtr_d  = sweepPtr_q;
        ghr_d       = ghr_q;
        predValid_d = predValid_q;
        predTaken_d = predTaken_q;
        predPc_d    = predPc_q;
        predGhr_d   = predGhr_q;
        initDone_d  = initDone_q;
        if (rdy) begin
            predValid_d = query_valid;
            if (query_valid) begin
                predTaken_d = queryTaken;
                predPc_d    = queryTarget;
                predGhr_d   = ghr_q;
            end
            if (state_q == INIT) begin
                sweepPtr_d = sweepPtr_q + IDX_W'(1);
                if (sweepPtr_q == LAST_IDX) begin
                    state_d    = RUN;
                    initDone_d = 1'b1;
                end
            end else begin
                if (query_valid && isBranch) begin
                    ghr_d = ghrShifted;
                end
                // Repair wins over a same-cycle speculative shift; fetch flushes that prediction.
                if (commit_valid && commit_mispredict) begin
                    ghr_d = ghrRepaired;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= INIT;
            sweepPtr_q  <= '0;
            ghr_q       <= '0;
            predValid_q <= 1'b0;
            predTaken_q <= 1'b0;
            predPc_q    <= '0;
            predGhr_q   <= '0;
            initDone_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweepPtr_q  <= sweepPtr_d;
            ghr_q       <= ghr_d;
            predValid_q <= predValid_d;
            predTaken_q <= predTaken_d;
            predPc_q    <= predPc_d;
            predGhr_q   <= predGhr_d;
            initDone_q  <= initDone_d;
        end
    end

    // The counter array has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (rst && rdy) begin
            if (state_q == INIT) begin
                table_q[sweepPtr_q] <= CNT_INIT;
            end else if (commit_valid) begin
                table_q[commitIdx] <= commitCntNext;
            end
        end
    end

    assign pred_valid = predValid_q;
    assign pred_taken = predTaken_q;
    assign pred_pc    = predPc_q;
    assign pred_ghr   = predGhr_q;
    assign init_done  = initDone_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor (IDX_W=4, CNT_W=2, GHR_W=4): directed
// queries push expected predictions, a negedge monitor pops and compares them.
module tb_gshare_predictor;

    localparam int IDX_W = 4;
    localparam int CNT_W = 2;
    localparam int GHR_W = 4;

    typedef struct packed {
        logic             taken;
        logic [31:0]      pc;
        logic [GHR_W-1:0] ghr;
    } pred_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy;
    logic             queryValid;
    logic [31:0]      queryPc;
    logic [31:0]      queryInstr;
    logic             predValid;
    logic             predTaken;
    logic [31:0]      predPc;
    logic [GHR_W-1:0] predGhr;
    logic             commitValid;
    logic [31:0]      commitPc;
    logic [GHR_W-1:0] commitGhr;
    logic             commitTaken;
    logic             commitMispredict;
    logic             initDone;

    pred_t expQ[$];
    pred_t popped;
    int    checksTotal  = 0;
    int    checksPassed = 0;
    int    doneAt;

    gshare_predictor #(
        .IDX_W(IDX_W),
        .CNT_W(CNT_W),
        .GHR_W(GHR_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .query_valid      (queryValid),
        .query_pc         (queryPc),
        .query_instr      (queryInstr),
        .pred_valid       (predValid),
        .pred_taken       (predTaken),
        .pred_pc          (predPc),
        .pred_ghr         (predGhr),
        .commit_valid     (commitValid),
        .commit_pc        (commitPc),
        .commit_ghr       (commitGhr),
        .commit_taken     (commitTaken),
        .commit_mispredict(commitMispredict),
        .init_done        (initDone)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] encB(input int off);
        logic [12:0] imm;
        imm = off[12:0];
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] encJ(input int off);
        logic [20:0] imm;
        imm = off[20:0];
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checksTotal++;
        if (actual === required) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic qv, input logic [31:0] qpc, input logic [31:0] qinstr,
                                 input logic cv, input logic [31:0] cpc, input logic [GHR_W-1:0] cghr,
                                 input logic ct, input logic cm);
        queryValid       = qv;
        queryPc          = qpc;
        queryInstr       = qinstr;
        commitValid      = cv;
        commitPc         = cpc;
        commitGhr        = cghr;
        commitTaken      = ct;
        commitMispredict = cm;
        @(posedge clk);
        #1;
        queryValid       = 1'b0;
        commitValid      = 1'b0;
        commitMispredict = 1'b0;
    endtask

    task automatic expectPred(input logic taken, input logic [31:0] pc, input logic [GHR_W-1:0] ghr);
        pred_t e;
        e.taken = taken;
        e.pc    = pc;
        e.ghr   = ghr;
        expQ.push_back(e);
    endtask

    task automatic query(input logic [31:0] pc, input logic [31:0] instr);
        applyStimulus(1'b1, pc, instr, 1'b0, 32'd0, '0, 1'b0, 1'b0);
    endtask

    task automatic commit(input logic [31:0] pc, input logic [GHR_W-1:0] ghr, input logic taken, input logic misp);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, pc, ghr, taken, misp);
    endtask

    // Forces the GHR through a mispredict repair; it trains a scratch entry (idx 14 or 15).
    task automatic setGhr(input logic [GHR_W-1:0] v);
        commit(32'h3C, {1'b0, v[3:1]}, v[0], 1'b1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " pred_valid"}, 64'(predValid), 64'd0);
        checkOutput({tag, " pred_taken"}, 64'(predTaken), 64'd0);
        checkOutput({tag, " pred_pc"}, 64'(predPc), 64'd0);
        checkOutput({tag, " pred_ghr"}, 64'(predGhr), 64'd0);
        checkOutput({tag, " init_done"}, 64'(initDone), 64'd0);
    endtask

    // Scoreboard monitor: every visible pred_valid consumes one expected prediction.
    always @(negedge clk) begin
        if (rst && predValid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected pred_valid", 64'd1, 64'd0);
            end else begin
                popped = expQ.pop_front();
                checkOutput("pred_taken", 64'(predTaken), 64'(popped.taken));
                checkOutput("pred_pc", 64'(predPc), 64'(popped.pc));
                checkOutput("pred_ghr", 64'(predGhr), 64'(popped.ghr));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        rdy = 1'b0;
        queryValid = 1'b0; queryPc = '0; queryInstr = '0;
        commitValid = 1'b0; commitPc = '0; commitGhr = '0;
        commitTaken = 1'b0; commitMispredict = 1'b0;
        #2;
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Sweep with rdy held low for three cycles in the middle.
        doneAt = 0;
        for (int n = 1; n <= 40 && doneAt == 0; n++) begin
            rdy = !(n >= 9 && n <= 11);
            @(posedge clk);
            #1;
            if (initDone) doneAt = n;
        end
        rdy = 1'b1;
        checkOutput("init cycles with stall", 64'(doneAt), 64'd19);

        expectPred(1'b0, 32'h104, 4'h0); query(32'h100, encB(-8));
        expectPred(1'b1, 32'hA00, 4'h0); query(32'h200, encJ(32'h800));
        // rdy low: prediction registers (and pred_valid) hold for another cycle.
        expectPred(1'b1, 32'hA00, 4'h0);
        rdy = 1'b0; query(32'h300, encB(-8)); rdy = 1'b1;

        commit(32'h100, 4'h0, 1'b1, 1'b0);
        commit(32'h100, 4'h0, 1'b1, 1'b0);
        expectPred(1'b1, 32'hF8, 4'h0); query(32'h100, encB(-8));
        commit(32'h100, 4'h0, 1'b1, 1'b0);
        commit(32'h100, 4'h0, 1'b0, 1'b0);
        setGhr(4'h0);
        expectPred(1'b1, 32'hF8, 4'h0); query(32'h100, encB(-8));
        for (int k = 0; k < 3; k++) commit(32'h100, 4'h0, 1'b0, 1'b0);
        commit(32'h100, 4'h0, 1'b1, 1'b0);
        setGhr(4'h0);
        expectPred(1'b0, 32'h104, 4'h0); query(32'h100, encB(-8));
        commit(32'h100, 4'h0, 1'b1, 1'b0);
        expectPred(1'b1, 32'hF8, 4'h0); query(32'h100, encB(-8));

        // Three predicted-taken branches all landing on idx 0 build GHR=0111.
        setGhr(4'h0);
        expectPred(1'b1, 32'hF8, 4'h0); query(32'h100, encB(-8));
        expectPred(1'b1, 32'hFC, 4'h1); query(32'h104, encB(-8));
        expectPred(1'b1, 32'h104, 4'h3); query(32'h10C, encB(-8));
        expectPred(1'b0, 32'h104, 4'h7);
        applyStimulus(1'b1, 32'h100, encB(-8), 1'b1, 32'h3C, 4'b0001, 1'b0, 1'b1);
        expectPred(1'b1, 32'hA00, 4'h2); query(32'h200, encJ(32'h800));

        // Same-cycle query and commit on idx 2 (counter 1): old value is read.
        expectPred(1'b0, 32'h104, 4'h2);
        applyStimulus(1'b1, 32'h100, encB(-8), 1'b1, 32'h100, 4'b0010, 1'b1, 1'b0);
        setGhr(4'h2);
        expectPred(1'b1, 32'hF8, 4'h2); query(32'h100, encB(-8));

        // Asynchronous reset while a prediction is being presented.
        query(32'h200, encJ(32'h800));
        #1;
        rst = 1'b0;
        #1;
        checkResetOutputs("async reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        doneAt = 0;
        for (int n = 1; n <= 40 && doneAt == 0; n++) begin
            queryValid = 1'b0; commitValid = 1'b0;
            if (n == 1) begin
                expectPred(1'b1, 32'hA00, 4'h0);
                queryValid = 1'b1; queryPc = 32'h200; queryInstr = encJ(32'h800);
            end else if (n == 2) begin
                expectPred(1'b0, 32'h104, 4'h0);
                queryValid = 1'b1; queryPc = 32'h100; queryInstr = encB(-8);
            end else if (n == 3 || n == 4) begin
                commitValid = 1'b1; commitPc = 32'h100; commitGhr = 4'h0; commitTaken = 1'b1;
            end
            @(posedge clk);
            #1;
            if (initDone) doneAt = n;
        end
        queryValid = 1'b0; commitValid = 1'b0;
        checkOutput("init cycles after reset", 64'(doneAt), 64'd16);
        expectPred(1'b0, 32'h104, 4'h0); query(32'h100, encB(-8));

        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
